uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver sitting directly downstream of the UART transmitter. It recovers bytes from the transmitter's line format:
- start bit (0)
- 8 data bits, LSB first
- stop bit (1)
- odd-parity bit, sent after the stop bit

Each bit lasts CLKS_PER_BIT clocks, with the same clock and same parameter value as the transmitter. Each received byte is presented with a one-cycle valid strobe plus parity and framing status for the consuming logic.

Parameters:
- CLKS_PER_BIT, 2, clock cycles per bit (clock freq / baud rate); legal range 2..255; must equal the transmitter's setting.
- HALF_BIT, CLKS_PER_BIT/2, mid-bit sample offset; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  8  last received byte; holds until the next frame completes.
- data_valid  output  1  one-cycle pulse: data_out and error flags updated.
- parity_error  output  1  valid with data_valid; 1 if data plus parity bit has an even count of ones.
- framing_error  output  1  valid with data_valid; 1 if the sampled stop bit was 0.
- busy  output  1  high from start-bit detect until the cycle data_valid pulses; low in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=8'h00, data_valid=0, parity_error=0, framing_error=0, busy=0.
  - FSM=IDLE, counters=0, synchroniser flops=1.
  - Reset mid-frame abandons the frame with no data_valid.
- Synchroniser: rx passes through 2 flops; rx_s is the second flop output. All decisions use rx_s; this adds 2 cycles of input latency.
- States: IDLE, START, DATA, STOP, PARITY, DONE; 3-bit encoding.
- IDLE:
  - busy=0.
  - rx_s=0 → START, clock counter=0, busy=1.
- START: count to HALF_BIT-1, then re-sample.
  - rx_s=0 → DATA, counter=0, bit_index=0.
  - rx_s=1 → glitch: return to IDLE, busy=0, no strobe, flags unchanged.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rx_s into shift register position bit_index (LSB first).
  - After bit_index=7 is sampled → STOP.
- STOP: after CLKS_PER_BIT clocks, sample rx_s; stop_bad = ~rx_s. Go to PARITY regardless of stop_bad.
- PARITY: after CLKS_PER_BIT clocks, sample rx_s as par; → DONE.
- DONE (one cycle):
  - data_out <= shift register.
  - parity_error <= ^{shift register, par}==0.
  - framing_error <= stop_bad.
  - data_valid=1, busy=0.
  - Next state IDLE.
  - A new start bit can be detected in the following cycle.
- data_valid is high for exactly one clock and is never asserted for aborted frames.
- Sample timing: with start detected in IDLE at edge t (rx_s low), samples occur at t+HALF_BIT+k*CLKS_PER_BIT:
  - k=0: start re-check
  - k=1..8: data bits
  - k=9: stop bit
  - k=10: parity bit
- Frame delivery even with errors: framing or parity error still delivers the byte with data_valid and the flag set.
- Error flags hold until the next data_valid.
- Line held low indefinitely: after a framing-error frame the FSM returns to IDLE, sees rx_s=0, and starts a new frame. Each such frame reports framing_error=1 and byte 8'h00.
- Counter width: $clog2(CLKS_PER_BIT)+1 bits; no wrap within a bit period.

Decomposition:
- Shared package uart_pkg:
  - state encodings (IDLE..DONE)
  - DATA_BITS=8
  - default CLKS_PER_BIT
  - parity-polarity constant (odd)
- The transmitter is to migrate its state constants to uart_pkg later.
- One sub-module: uart_sync2 (2-flop synchroniser, reset value 1, async active-low reset).

Test Plan:
- Loopback: transmitter (CLKs_per_bit=2) drives rx; send 8'hA5 → one data_valid, data_out=8'hA5, parity_error=0, framing_error=0, busy low after the strobe.
- Back-to-back: send 8'h00 then 8'hFF through loopback → two data_valid pulses in order, values 8'h00 and 8'hFF, both error flags 0 each time.
- Glitch rejection (CLKS_PER_BIT=16): drive rx low for 3 clocks, then high → no data_valid, busy returns to 0, FSM back in IDLE.
- Framing error: hand-built frame for 8'h3C with stop bit=0 and correct parity bit=1 → data_valid, data_out=8'h3C, framing_error=1, parity_error=0.
- Parity error: frame for 8'h01 with parity bit=1 (correct is 0) → data_out=8'h01, parity_error=1, framing_error=0.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 8'h5A → outputs immediately at reset values. After release, a following clean 8'hC3 frame is received correctly with no spurious strobe.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, frame constants and parity helper
// Ports: none (package).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4,
      ST_DONE   = 3'd5
   } uart_state_e;

   localparam int   DATA_BITS            = 8;
   localparam int   CLKS_PER_BIT_DEFAULT = 2;
   // 1 = odd parity: data plus parity bit carries an odd number of ones.
   localparam logic PARITY_ODD           = 1'b1;

   // Parity bit a transmitter appends for the given byte.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return PARITY_ODD ? ~(^d) : (^d);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an idle-high asynchronous line
// Ports: clk (clock), rst_n (async active-low reset), d (async input), q (synchronised output).
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Reset to 1 so an idle line never looks like a start bit on reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, 8 data LSB first, stop, odd parity after stop
// Ports: clk, rst_n (async active-low), rx (serial line, idles high),
//        data_out (last byte), data_valid (1-cycle strobe), parity_error,
//        framing_error (both valid with data_valid), busy (frame in progress).
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 busy
);

   localparam int             HALF_BIT  = CLKS_PER_BIT / 2;
   localparam int             CW        = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);

   uart_state_e          state, state_nxt;
   logic                 rx_s;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 stop_bad;
   logic                 tick_half;
   logic                 tick_bit;

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   // The counter restarts at 0 on each sample edge, so a match on LAST
   // lands exactly one half/full bit period after the previous sample.
   assign tick_half = (cnt == HALF_LAST);
   assign tick_bit  = (cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (!rx_s) state_nxt = ST_START;
         ST_START:  if (tick_half) state_nxt = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (tick_bit && (bit_idx == IDX_LAST)) state_nxt = ST_STOP;
         ST_STOP:   if (tick_bit) state_nxt = ST_PARITY;
         ST_PARITY: if (tick_bit) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         stop_bad      <= 1'b0;
         data_out      <= '0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         case (state)
            ST_START: begin
               if (tick_half) begin
                  cnt     <= '0;
                  bit_idx <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (tick_bit) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (tick_bit) begin
                  cnt      <= '0;
                  stop_bad <= ~rx_s;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               // Results are loaded on entry to DONE so they are already
               // stable during the data_valid cycle.
               if (tick_bit) begin
                  cnt           <= '0;
                  data_out      <= shreg;
                  parity_error  <= ((^{shreg, rx_s}) != PARITY_ODD);
                  framing_error <= stop_bad;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               cnt     <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

   assign data_valid = (state == ST_DONE);
   assign busy       = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_STOP)  || (state == ST_PARITY);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       rx16;
   logic [7:0] data_out, data_out16;
   logic       data_valid, data_valid16;
   logic       parity_error, parity_error16;
   logic       framing_error, framing_error16;
   logic       busy, busy16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .parity_error  (parity_error),
      .framing_error (framing_error),
      .busy          (busy)
   );

   uart_rx #(.CLKS_PER_BIT(16)) dut16 (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx16),
      .data_out      (data_out16),
      .data_valid    (data_valid16),
      .parity_error  (parity_error16),
      .framing_error (framing_error16),
      .busy          (busy16)
   );

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } rec_t;

   typedef struct {
      string      name;
      logic [7:0] d;
      logic       stop;
      logic       par;
      logic [7:0] ed;
      logic       epe;
      logic       efe;
   } vec_t;

   rec_t q[$];
   rec_t q16[$];
   vec_t vecs[6];

   always @(negedge clk) begin
      if (data_valid)   q.push_back('{data_out, parity_error, framing_error});
      if (data_valid16) q16.push_back('{data_out16, parity_error16, framing_error16});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serialise one frame the way the transmitter does, followed by one idle bit.
   task automatic send(input int clks, input bit sel, input logic [7:0] d,
                       input logic stop, input logic par);
      logic [10:0] f;
      f = {par, stop, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (sel) rx16 = f[i];
         else     rx   = f[i];
         tick(clks);
      end
      if (sel) rx16 = 1'b1;
      else     rx   = 1'b1;
      tick(clks);
   endtask

   task automatic expect_frame(input string nm, input bit sel, input int budget,
                               input logic [7:0] ed, input logic epe, input logic efe);
      int   n;
      int   cnt;
      rec_t r;
      n = 0;
      while (((sel ? q16.size() : q.size()) == 0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cnt = sel ? q16.size() : q.size();
      chk({nm, ".strobes"}, cnt, 1);
      if (cnt > 0) begin
         r = sel ? q16.pop_front() : q.pop_front();
         chk({nm, ".data"}, r.d, ed);
         chk({nm, ".parity_error"}, r.pe, epe);
         chk({nm, ".framing_error"}, r.fe, efe);
      end
      chk({nm, ".busy_after"}, sel ? busy16 : busy, 0);
      q.delete();
      q16.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       stop, par, good_par;
      logic [7:0] pre;

      // Expectations worked out by hand from the frame rules (odd parity).
      vecs[0] = '{"a5_ok",     8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{"b2b_00",    8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{"b2b_ff",    8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{"framing",   8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
      vecs[4] = '{"parity",    8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{"both_err",  8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};

      rst_n = 1'b0;
      rx    = 1'b1;
      rx16  = 1'b1;
      tick(3);
      @(negedge clk);
      chk("reset.data_out", data_out, 8'h00);
      chk("reset.data_valid", data_valid, 0);
      chk("reset.parity_error", parity_error, 0);
      chk("reset.framing_error", framing_error, 0);
      chk("reset.busy", busy, 0);
      rst_n = 1'b1;
      tick(4);

      for (int i = 0; i < 6; i++) begin
         send(2, 1'b0, vecs[i].d, vecs[i].stop, vecs[i].par);
         expect_frame(vecs[i].name, 1'b0, 60, vecs[i].ed, vecs[i].epe, vecs[i].efe);
      end

      // Line stuck low: consecutive all-zero frames, each with both errors.
      rx = 1'b0;
      tick(60);
      chk("stuck_low.frames", (q.size() >= 2), 1);
      for (int i = 0; i < q.size(); i++) begin
         chk("stuck_low.data", q[i].d, 8'h00);
         chk("stuck_low.framing_error", q[i].fe, 1);
         chk("stuck_low.parity_error", q[i].pe, 1);
      end
      rx = 1'b1;
      tick(60);
      q.delete();

      // Random frames against the arithmetic model.
      for (int i = 0; i < 20; i++) begin
         d        = 8'($urandom);
         good_par = (($countones(d) % 2) == 0);
         stop     = ($urandom_range(0, 3) != 0);
         par      = ($urandom_range(0, 3) != 0) ? good_par : ~good_par;
         send(2, 1'b0, d, stop, par);
         expect_frame("random", 1'b0, 60, d,
                      ((($countones(d) + par) % 2) == 0), ~stop);
      end

      // Known non-zero byte so the reset clear is visible.
      send(2, 1'b0, 8'h7E, 1'b1, 1'b1);
      expect_frame("pre_reset", 1'b0, 60, 8'h7E, 1'b0, 1'b0);
      pre = 8'h5A;
      rx  = 1'b0;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         rx = pre[i];
         tick(2);
      end
      rx = pre[4];
      tick(1);
      chk("midreset.busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midreset.data_out", data_out, 8'h00);
      chk("midreset.data_valid", data_valid, 0);
      chk("midreset.parity_error", parity_error, 0);
      chk("midreset.framing_error", framing_error, 0);
      chk("midreset.busy", busy, 0);
      rx = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(40);
      chk("midreset.no_strobe", q.size(), 0);
      send(2, 1'b0, 8'hC3, 1'b1, 1'b1);
      expect_frame("after_reset", 1'b0, 60, 8'hC3, 1'b0, 1'b0);

      // Glitch at 16 clocks per bit: 3-clock low pulse must be rejected.
      rx16 = 1'b0;
      tick(3);
      rx16 = 1'b1;
      @(negedge clk);
      chk("glitch.busy_seen", busy16, 1);
      tick(30);
      @(negedge clk);
      chk("glitch.no_strobe", q16.size(), 0);
      chk("glitch.busy_low", busy16, 0);

      send(16, 1'b1, 8'h96, 1'b1, 1'b1);
      expect_frame("slow_ok", 1'b1, 100, 8'h96, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
